// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/enable/delegation unit: synchronised sources, edge/level local
// lines, mie/sie/mideleg/lmode storage and a registered request/ack handshake.
module irq_pending_ctrl #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned NLOCAL      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_time_int,
  input  logic              m_soft_int,
  input  logic              m_ext_int,
  input  logic              s_ext_int,
  input  logic [NLOCAL-1:0] lcl_int,
  input  logic              mip_sel,
  input  logic              sip_sel,
  input  logic              mie_sel,
  input  logic              sie_sel,
  input  logic              mideleg_sel,
  input  logic              lmode_sel,
  input  logic              csr_write,
  input  logic [XLEN-1:0]   data_csr,
  output logic [XLEN-1:0]   csr_rdata,
  input  logic [1:0]        priv,
  input  logic              mstatus_mie,
  input  logic              mstatus_sie,
  output logic              int_req,
  output logic              int_deleg,
  output logic [5:0]        int_cause,
  input  logic              int_ack
);

  localparam int unsigned NIN = NLOCAL + 4;

  function automatic logic [XLEN-1:0] local_bits();
    logic [XLEN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NLOCAL; i++) m[16+i] = 1'b1;
    return m;
  endfunction

  localparam logic [XLEN-1:0] MIE_MASK   = local_bits() | XLEN'(12'hAAA);
  localparam logic [XLEN-1:0] DELEG_MASK = local_bits() | XLEN'(12'h222);

  // Lowest priority assigned first so the last matching assignment wins.
  function automatic logic [5:0] pick(input logic [XLEN-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int unsigned i = NLOCAL; i > 0; i--) if (v[16+i-1]) c = 6'(16 + i - 1);
    if (v[5])  c = 6'd5;
    if (v[1])  c = 6'd1;
    if (v[9])  c = 6'd9;
    if (v[7])  c = 6'd7;
    if (v[3])  c = 6'd3;
    if (v[11]) c = 6'd11;
    return c;
  endfunction

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state;

  logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
  logic [NIN-1:0]    synced;
  logic [NLOCAL-1:0] lcl_s, lcl_prev, lcl_pend, lcl_next, lcl_clr, new_mode, lmode;
  logic              mtip, msip, meip, seip_hw, ssip, stip, seip_sw;
  logic [XLEN-1:0]   mie, mideleg, mip, cand, take_nd, take_dl;
  logic              nd_en, dl_en, any_take, ack_clr, win_deleg;
  logic [5:0]        win_cause;

  assign synced = sync_q[SYNC_STAGES-1];
  assign lcl_s  = synced[NIN-1:4];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else begin
      sync_q[0] <= {lcl_int, s_ext_int, m_ext_int, m_soft_int, m_time_int};
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_comb begin
    mip               = '0;
    mip[1]            = ssip;
    mip[3]            = msip;
    mip[5]            = stip;
    mip[7]            = mtip;
    mip[9]            = seip_sw | seip_hw;
    mip[11]           = meip;
    mip[16 +: NLOCAL] = lcl_pend;
  end

  always_comb begin
    csr_rdata = '0;
    if (mip_sel)          csr_rdata = mip;
    else if (sip_sel)     csr_rdata = mip & mideleg;
    else if (mie_sel)     csr_rdata = mie;
    else if (sie_sel)     csr_rdata = mie & mideleg;
    else if (mideleg_sel) csr_rdata = mideleg;
    else if (lmode_sel)   csr_rdata = XLEN'(lmode);
  end

  always_comb begin
    cand      = mip & mie;
    nd_en     = (priv != 2'd3) || mstatus_mie;
    dl_en     = (priv == 2'd0) || ((priv == 2'd1) && mstatus_sie);
    take_nd   = nd_en ? (cand & ~mideleg) : '0;
    take_dl   = dl_en ? (cand & mideleg) : '0;
    any_take  = (|take_nd) || (|take_dl);
    win_deleg = ~(|take_nd);
    win_cause = pick((|take_nd) ? take_nd : take_dl);
    ack_clr   = (state == REQ) && any_take && int_ack;
  end

  // Lines are evaluated in the mode they will have after this edge; a mode change
  // counts as a clear, and a rising edge in the same cycle still sets the bit.
  always_comb begin
    new_mode = (lmode_sel && csr_write) ? data_csr[NLOCAL-1:0] : lmode;
    lcl_clr  = new_mode ^ lmode;
    if (mip_sel && csr_write) lcl_clr |= ~data_csr[16 +: NLOCAL];
    for (int unsigned i = 0; i < NLOCAL; i++)
      if (ack_clr && (int_cause == 6'(16 + i))) lcl_clr[i] = 1'b1;
    lcl_next = (new_mode & ((lcl_s & ~lcl_prev) | (lcl_pend & ~lcl_clr)))
             | (~new_mode & lcl_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {mtip, msip, meip, seip_hw, ssip, stip, seip_sw} <= '0;
      lcl_prev <= '0;
      lcl_pend <= '0;
      lmode    <= '0;
      mie      <= '0;
      mideleg  <= '0;
    end else begin
      mtip     <= synced[0];
      msip     <= synced[1];
      meip     <= synced[2];
      seip_hw  <= synced[3];
      lcl_prev <= lcl_s;
      lcl_pend <= lcl_next;
      lmode    <= new_mode;
      if (csr_write && mip_sel) begin
        ssip    <= data_csr[1];
        stip    <= data_csr[5];
        seip_sw <= data_csr[9];
      end
      if (csr_write && sip_sel && mideleg[1]) ssip <= data_csr[1];
      if (csr_write && mie_sel) mie <= data_csr & MIE_MASK;
      if (csr_write && sie_sel) mie <= (mie & ~mideleg) | (data_csr & mideleg);
      if (csr_write && mideleg_sel) mideleg <= data_csr & DELEG_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      int_req   <= 1'b0;
      int_deleg <= 1'b0;
      int_cause <= '0;
    end else begin
      case (state)
        IDLE: if (any_take) begin
          int_req   <= 1'b1;
          int_cause <= win_cause;
          int_deleg <= win_deleg;
          state     <= REQ;
        end
        REQ: begin
          if (!any_take) begin
            int_req <= 1'b0;
            state   <= IDLE;
          end else if (int_ack) begin
            int_req <= 1'b0;
            state   <= HOLD;
          end else begin
            int_cause <= win_cause;
            int_deleg <= win_deleg;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the pending/priority rules.
module tb_irq_pending_ctrl;
  localparam int unsigned XLEN = 64;
  localparam int unsigned NLOCAL = 16;
  localparam int unsigned SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, ti = 0, si = 0, ei = 0, sei = 0, wr = 0, ack = 0;
  logic              mmie = 0, msie = 0;
  logic [1:0]        priv = 2'd3;
  logic [NLOCAL-1:0] lcl = '0;
  logic [XLEN-1:0]   wdata = '0;
  int                sel = 0;
  logic [XLEN-1:0]   csr_rdata;
  logic              int_req, int_deleg;
  logic [5:0]        int_cause;

  irq_pending_ctrl #(.XLEN(XLEN), .NLOCAL(NLOCAL), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .m_time_int(ti), .m_soft_int(si), .m_ext_int(ei),
    .s_ext_int(sei), .lcl_int(lcl), .mip_sel(sel == 1), .sip_sel(sel == 2),
    .mie_sel(sel == 3), .sie_sel(sel == 4), .mideleg_sel(sel == 5),
    .lmode_sel(sel == 6), .csr_write(wr), .data_csr(wdata), .csr_rdata(csr_rdata),
    .priv(priv), .mstatus_mie(mmie), .mstatus_sie(msie), .int_req(int_req),
    .int_deleg(int_deleg), .int_cause(int_cause), .int_ack(ack)
  );

  int unsigned n_vec = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [NLOCAL-1:0] l;
    logic sx, mx, ms, mt;
  } raw_t;

  raw_t              hist[$];
  int                prio[$];
  bit                m_ssip, m_stip, m_seip_sw, m_mt, m_ms, m_me, m_sx;
  bit [NLOCAL-1:0]   m_lp, m_lmode;
  bit [63:0]         m_mie, m_deleg, mie_wmask, deleg_wmask;
  bit                m_req, m_hold, m_dl;
  int                m_cause;

  task automatic model_reset();
    raw_t z;
    z = '0;
    hist.delete();
    for (int i = 0; i <= int'(SS); i++) hist.push_back(z);
    {m_ssip, m_stip, m_seip_sw, m_mt, m_ms, m_me, m_sx} = '0;
    m_lp = '0; m_lmode = '0; m_mie = '0; m_deleg = '0;
    m_req = 0; m_hold = 0; m_dl = 0; m_cause = 0;
  endtask

  function automatic bit [63:0] mip_model();
    bit [63:0] m;
    m = '0;
    m[1] = m_ssip; m[3] = m_ms; m[5] = m_stip; m[7] = m_mt;
    m[9] = m_seip_sw | m_sx; m[11] = m_me;
    for (int i = 0; i < int'(NLOCAL); i++) m[16+i] = m_lp[i];
    return m;
  endfunction

  function automatic bit [63:0] read_model();
    case (sel)
      1: return mip_model();
      2: return mip_model() & m_deleg;
      3: return m_mie;
      4: return m_mie & m_deleg;
      5: return m_deleg;
      6: return 64'(m_lmode);
      default: return '0;
    endcase
  endfunction

  // Non-delegated class first, then delegated; within a class the prio list order.
  task automatic winner(output bit found, output int cause, output bit dl);
    bit [63:0] m;
    m = mip_model();
    found = 0; cause = 0; dl = 0;
    for (int cls = 0; cls < 2; cls++)
      foreach (prio[k]) begin
        int c;
        bit is_dl, ok;
        c = prio[k];
        is_dl = m_deleg[c];
        ok = is_dl ? (priv == 2'd0 || (priv == 2'd1 && msie)) : (priv != 2'd3 || mmie);
        if (!found && m[c] && m_mie[c] && ok && (is_dl == (cls == 1))) begin
          found = 1; cause = c; dl = is_dl;
        end
      end
  endtask

  task automatic model_next();
    raw_t syn, prv, now;
    bit found, wd;
    int wc;
    bit [NLOCAL-1:0] nm, nlp;
    if (rst) begin
      model_reset();
      return;
    end
    syn = hist[SS-1];
    prv = hist[SS];
    winner(found, wc, wd);
    for (int i = 0; i < int'(NLOCAL); i++) begin
      nm[i] = (wr && sel == 6) ? wdata[i] : m_lmode[i];
      if (!nm[i]) nlp[i] = syn.l[i];
      else begin
        bit setb, clr;
        setb = syn.l[i] && !prv.l[i];
        clr = (nm[i] != m_lmode[i]) || (wr && sel == 1 && !wdata[16+i]) ||
              (m_req && !m_hold && found && ack && m_cause == 16 + i);
        nlp[i] = setb || (m_lp[i] && !clr);
      end
    end
    if (m_hold) m_hold = 0;
    else if (!m_req) begin
      if (found) begin m_req = 1; m_cause = wc; m_dl = wd; end
    end else if (!found) m_req = 0;
    else if (ack) begin m_req = 0; m_hold = 1; end
    else begin m_cause = wc; m_dl = wd; end
    if (wr && sel == 1) begin m_ssip = wdata[1]; m_stip = wdata[5]; m_seip_sw = wdata[9]; end
    if (wr && sel == 2 && m_deleg[1]) m_ssip = wdata[1];
    if (wr && sel == 3) m_mie = wdata & mie_wmask;
    if (wr && sel == 4) m_mie = (m_mie & ~m_deleg) | (wdata & m_deleg);
    if (wr && sel == 5) m_deleg = wdata & deleg_wmask;
    m_mt = syn.mt; m_ms = syn.ms; m_me = syn.mx; m_sx = syn.sx;
    m_lp = nlp; m_lmode = nm;
    now.l = lcl; now.sx = sei; now.mx = ei; now.ms = si; now.mt = ti;
    hist.push_front(now);
    void'(hist.pop_back());
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    #1;
    check_eq("rdata", csr_rdata, read_model());
    model_next();
    @(posedge clk);
    @(negedge clk);
    check_eq("req", int_req, m_req);
    if (m_req) begin
      check_eq("cause", int_cause, m_cause);
      check_eq("deleg", int_deleg, m_dl);
    end
  endtask

  task automatic csr_wr(input int s, input logic [63:0] d);
    sel = s; wr = 1; wdata = d;
    step();
    sel = 0; wr = 0; wdata = '0;
  endtask

  task automatic expect_bit(input int s, input int idx, input bit exp, input string tag);
    sel = s;
    #1 check_eq(tag, csr_rdata[idx], exp);
    step();
    sel = 0;
  endtask

  initial begin
    foreach (prio[k]) ;
    prio = '{11, 3, 7, 9, 1, 5};
    for (int i = 0; i < int'(NLOCAL); i++) prio.push_back(16 + i);
    mie_wmask = '0; deleg_wmask = '0;
    foreach (prio[k]) mie_wmask[prio[k]] = 1'b1;
    foreach (prio[k]) if (prio[k] == 1 || prio[k] == 5 || prio[k] >= 9 && prio[k] != 11)
      deleg_wmask[prio[k]] = 1'b1;
    model_reset();
    @(negedge clk);

    // reset and idle
    rst = 1; step(); step(); rst = 0;
    for (int s = 1; s <= 6; s++) begin
      sel = s;
      #1 check_eq("csr_after_rst", csr_rdata, 64'd0);
      step();
    end
    sel = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("idle_req", int_req, 1'b0);
    end

    // machine timer + external, priority 11 then 7
    csr_wr(3, 64'h888); mmie = 1; priv = 2'd0; ti = 1; ei = 1;
    repeat (SS + 2) step();
    check_eq("m_ext_req", int_req, 1'b1);
    check_eq("m_ext_cause", int_cause, 6'd11);
    ei = 0;
    repeat (SS + 2) step();
    check_eq("m_time_cause", int_cause, 6'd7);
    ti = 0; csr_wr(3, 64'h0);
    repeat (SS + 3) step();

    // delegated supervisor timer, masked in M mode
    csr_wr(5, 64'h222); csr_wr(3, 64'h222); priv = 2'd1; msie = 1;
    csr_wr(1, 64'h20);
    step();
    check_eq("stip_req", int_req, 1'b1);
    check_eq("stip_deleg", int_deleg, 1'b1);
    check_eq("stip_cause", int_cause, 6'd5);
    priv = 2'd3;
    step();
    check_eq("stip_mmode_drop", int_req, 1'b0);
    csr_wr(1, 64'h0); csr_wr(5, 64'h0); csr_wr(3, 64'h0); priv = 2'd0;

    // edge line 0: pulse, request, ack, hold
    csr_wr(6, 64'h1); csr_wr(3, 64'h10000);
    lcl[0] = 1; step(); lcl[0] = 0;
    repeat (SS + 1) step();
    check_eq("edge_req", int_req, 1'b1);
    check_eq("edge_cause", int_cause, 6'd16);
    ack = 1; step(); ack = 0;
    check_eq("ack_drop", int_req, 1'b0);
    expect_bit(1, 16, 1'b0, "edge_cleared");
    check_eq("hold_low", int_req, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stay_low", int_req, 1'b0);
    end

    // ack coinciding with a new rising edge on the same line
    lcl[0] = 1; step(); lcl[0] = 0;
    repeat (SS + 1) step();
    lcl[0] = 1; step(); lcl[0] = 0;
    repeat (SS - 1) step();
    ack = 1; step(); ack = 0;
    check_eq("ack_edge_drop", int_req, 1'b0);
    expect_bit(1, 16, 1'b1, "edge_kept");
    check_eq("ack_edge_hold", int_req, 1'b0);
    step();
    check_eq("reassert_req", int_req, 1'b1);
    check_eq("reassert_cause", int_cause, 6'd16);
    csr_wr(1, 64'h0); csr_wr(6, 64'h0); csr_wr(3, 64'h0);
    repeat (3) step();

    // level line 3 ignores mip writes
    csr_wr(3, 64'h1 << 19); lcl[3] = 1;
    repeat (SS + 2) step();
    check_eq("level_cause", int_cause, 6'd19);
    csr_wr(1, 64'h0);
    expect_bit(1, 19, 1'b1, "level_kept");
    repeat (3) step();
    check_eq("level_req", int_req, 1'b1);
    check_eq("level_cause2", int_cause, 6'd19);
    lcl[3] = 0; csr_wr(3, 64'h0);
    repeat (SS + 3) step();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) ti = ~ti;
      if ($urandom_range(0, 39) == 0) si = ~si;
      if ($urandom_range(0, 39) == 0) ei = ~ei;
      if ($urandom_range(0, 39) == 0) sei = ~sei;
      if ($urandom_range(0, 7) == 0) lcl[$urandom_range(0, NLOCAL - 1)] ^= 1'b1;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0: priv = 2'd0;
          1: priv = 2'd1;
          default: priv = 2'd3;
        endcase
      end
      if ($urandom_range(0, 19) == 0) mmie = ~mmie;
      if ($urandom_range(0, 19) == 0) msie = ~msie;
      sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      wr = (sel != 0) && ($urandom_range(0, 1) == 0);
      wdata = {$urandom, $urandom};
      ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    sel = 0; wr = 0; ack = 0; rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Parametrised interrupt pending/enable/delegation unit for the CPU control unit. It replaces the fixed 6-bit pending logic with several additions: synchronised interrupt inputs, NLOCAL platform-local interrupt lines with per-line edge or level mode, and mie/sie/mideleg storage. It also selects the highest-priority takeable interrupt and presents it to the trap logic through a registered request/acknowledge handshake.

## Interface
- XLEN, 64, CSR data width
- NLOCAL, 16, number of local interrupt lines, mapped to cause/bit 16+i; legal range 0..XLEN-16
- SYNC_STAGES, 2, synchroniser depth on every interrupt input; legal range 1..4
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m_time_int, m_soft_int, m_ext_int, s_ext_int  in  1 each  asynchronous interrupt sources
- lcl_int  in  NLOCAL  asynchronous local interrupt lines
- mip_sel, sip_sel, mie_sel, sie_sel, mideleg_sel, lmode_sel  in  1 each  one-hot CSR selects (lmode is a custom CSR)
- csr_write  in  1  write strobe for the selected CSR
- data_csr  in  XLEN  write data
- csr_rdata  out  XLEN  read data of the selected CSR, combinational; 0 if nothing is selected
- priv  in  2  current privilege (0=U, 1=S, 3=M)
- mstatus_mie, mstatus_sie  in  1 each  global enables
- int_req  out  1  takeable interrupt present (registered)
- int_deleg  out  1  interrupt targets S mode (registered)
- int_cause  out  6  cause number of int_req (registered)
- int_ack  in  1  trap logic has taken the interrupt

## Operation
- All interrupt inputs pass through SYNC_STAGES flops, all reset to 0. Only synchronised values are used below.
- Standard pending bits: ssip 1, msip 3, stip 5, mtip 7, seip 9, meip 11.
  - msip, mtip, meip mirror the synced inputs and are read-only.
  - ssip, stip and seip_sw are writable through mip.
  - ssip is also writable through sip.
  - Read value of bit 9 is seip_sw | s_ext.
- Local line i, pending bit 16+i:
  - Level mode (lmode[i]=0): pending equals the synced level; writes are ignored.
  - Edge mode (lmode[i]=1): a synced rising edge sets pending. Pending is cleared by a mip write with bit 16+i = 0, or by an acknowledge of cause 16+i.
  - A set and a clear in the same cycle: set wins.
- mie writable mask is bits {1,3,5,7,9,11, 16..16+NLOCAL-1}. All other bits read 0.
- mideleg writable mask is bits {1,5,9, locals}. Bits 3, 7, 11 read 0.
- sip and sie are views masked by mideleg.
  - sip reads mip & mideleg; a sip write affects only ssip, and only if mideleg[1]=1.
  - sie reads mie & mideleg; a sie write updates mie only at delegated bits.
- lmode is NLOCAL bits at [NLOCAL-1:0]. Changing the mode of a line clears that line's edge pending bit.
- Takeable conditions: cand = mip & mie.
  - A non-delegated bit is takeable when priv != M or mstatus_mie = 1.
  - A delegated bit is takeable when priv = U, or when priv = S and mstatus_sie = 1. It is never takeable in M mode.
- Priority:
  - Any non-delegated takeable interrupt beats any delegated one.
  - Within a class the order is 11, 3, 7, 9, 1, 5, then locals with the lowest index highest.
- Request FSM:
  - IDLE: when any interrupt is takeable, load int_req=1 with its cause and deleg flag, then go to REQ.
  - REQ: int_cause and int_deleg re-track the current winner every cycle. If none remains takeable, drop int_req and return to IDLE. If int_ack=1, clear the edge pending bit of a local cause, drop int_req and go to HOLD.
  - HOLD: one cycle with int_req=0, then go to IDLE.
  - int_ack in IDLE or HOLD is ignored.

## Timing
- Reset values: all pending, mie, mideleg and lmode = 0; the synchroniser chain = 0; int_req = 0, int_deleg = 0, int_cause = 0; FSM in IDLE.
- An input toggle is visible in mip after SYNC_STAGES+1 cycles. For edge mode the edge detector adds 0 cycles beyond that.
- A pending/enable/priv change reaches int_req/int_cause one cycle later.
- A CSR write is visible on csr_rdata the cycle after csr_write.
- After an ack, int_req stays at 0 for at least 2 cycles: the ack cycle edge plus HOLD.
- An ack in the same cycle as a new edge on the acked line: the line stays pending.
- rst mid-request clears int_req the next edge, regardless of int_ack.

## Test plan
- Reset, then read every CSR -> all 0; int_req = 0 for 10 cycles while the inputs are idle.
- mie=0x888, mstatus_mie=1, priv=U; assert m_time_int and m_ext_int together -> after SYNC_STAGES+2 cycles, int_req=1 with int_cause=11. Then drop m_ext_int -> cause becomes 7.
- mideleg=0x222, mie=0x222, priv=S, mstatus_sie=1; write mip=0x20 -> int_req=1, int_deleg=1, cause=5. Set priv=M -> int_req falls within 1 cycle.
- lmode[0]=1, mie[16]=1; pulse lcl_int[0] high for 1 cycle -> mip[16]=1 and int_req with cause 16. Ack -> mip[16]=0, int_req low for 2 cycles, then it stays low.
- Edge line 0 pending with an ack arriving in the same cycle as a new rising edge -> mip[16] stays 1 and int_req reasserts after HOLD.
- Level line 3 high with mie[19]=1; write mip[19]=0 -> the write is ignored, mip[19]=1 and cause 19 is persistent.
